// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port RAM. It grants one access per cycle under
// bounded-burst round-robin and returns read data to the granted master one cycle later.
module mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M0_REQ,
  input  logic              M0_WREN,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_DATA,
  output logic              M0_GNT,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_Q,
  input  logic              M1_REQ,
  input  logic              M1_WREN,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_DATA,
  output logic              M1_GNT,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_Q,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WREN,
  output logic [DATA_W-1:0] RAM_DATA,
  input  logic [DATA_W-1:0] RAM_Q
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_q_q, m0_q_d;
  logic [DATA_W-1:0] m1_q_q, m1_q_d;
  logic              win0, win1;

  // The owner keeps the RAM unless the other master is waiting and the burst is used up.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win0 = 1'b0;
    win1 = 1'b0;
    case (owner_q)
      OWN0: begin
        if (M0_REQ && (!M1_REQ || cnt_q < CNT_MAX)) win0 = 1'b1;
        else                                        win1 = M1_REQ;
      end
      OWN1: begin
        if (M1_REQ && (!M0_REQ || cnt_q < CNT_MAX)) win1 = 1'b1;
        else                                        win0 = M0_REQ;
      end
      default: begin
        win0 = M0_REQ;
        win1 = !M0_REQ && M1_REQ;
      end
    endcase
  end

  assign M0_GNT = win0;
  assign M1_GNT = win1;

  always_comb begin
    RAM_ADDR = '0;
    RAM_DATA = '0;
    RAM_WREN = 1'b0;
    if (win0) begin
      RAM_ADDR = M0_ADDR;
      RAM_DATA = M0_DATA;
      RAM_WREN = M0_WREN;
    end else if (win1) begin
      RAM_ADDR = M1_ADDR;
      RAM_DATA = M1_DATA;
      RAM_WREN = M1_WREN;
    end
  end

  always_comb begin
    owner_d = IDLE;
    cnt_d   = '0;
    if (win0) begin
      owner_d = OWN0;
      cnt_d   = (owner_q != OWN0) ? CNT_ONE : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end else if (win1) begin
      owner_d = OWN1;
      cnt_d   = (owner_q != OWN1) ? CNT_ONE : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end
  end

  // RAM_Q is valid before the edge that ends the grant cycle, so it is captured here.
  always_comb begin
    m0_rvalid_d = win0 && !M0_WREN;
    m1_rvalid_d = win1 && !M1_WREN;
    m0_q_d      = m0_rvalid_d ? RAM_Q : m0_q_q;
    m1_q_d      = m1_rvalid_d ? RAM_Q : m1_q_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q     <= IDLE;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_q_q      <= '0;
      m1_q_q      <= '0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_q_q      <= m0_q_d;
      m1_q_q      <= m1_q_d;
    end
  end

  assign M0_RVALID = m0_rvalid_q;
  assign M1_RVALID = m1_rvalid_q;
  assign M0_Q      = m0_q_q;
  assign M1_Q      = m1_q_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a run-length arbitration model and a shadow memory.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk, rst;
  logic          m0_req, m0_wren, m1_req, m1_wren;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_data, m1_data;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_q, m1_q;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_data, ram_q;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .CLK(clk), .RST(rst),
    .M0_REQ(m0_req), .M0_WREN(m0_wren), .M0_ADDR(m0_addr), .M0_DATA(m0_data),
    .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid), .M0_Q(m0_q),
    .M1_REQ(m1_req), .M1_WREN(m1_wren), .M1_ADDR(m1_addr), .M1_DATA(m1_data),
    .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid), .M1_Q(m1_q),
    .RAM_ADDR(ram_addr), .RAM_WREN(ram_wren), .RAM_DATA(ram_data), .RAM_Q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM clocked on the falling edge, as the real part is.
  logic [DW-1:0] ram_mem [4096];
  always @(negedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current owner (-1 none) and length of its consecutive run.
  int            mdl_owner, mdl_run, last_win;
  logic [DW-1:0] ref_mem [4096];
  logic          exp_rv0, exp_rv1;
  logic [DW-1:0] exp_q0, exp_q1;

  // Values sampled / predicted for the cycle most recently stepped.
  logic [1:0]    obs_gnt, exp_gnt, obs_rv, now_rv;
  logic [28:0]   obs_ram, exp_ram;
  logic [DW-1:0] obs_q0, obs_q1, now_q0, now_q1;
  logic [1:0]    obs_owner;
  int            obs_cnt;

  function automatic int pick();
    logic own_req, oth_req;
    if (mdl_owner < 0) return m0_req ? 0 : (m1_req ? 1 : -1);
    own_req = (mdl_owner == 0) ? m0_req : m1_req;
    oth_req = (mdl_owner == 0) ? m1_req : m0_req;
    if (own_req && (!oth_req || mdl_run < MB)) return mdl_owner;
    if (oth_req) return 1 - mdl_owner;
    return -1;
  endfunction

  // One clock cycle: sample DUT at the falling edge, predict, then advance the model.
  task automatic cycle();
    int            w;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    obs_gnt   = {m0_gnt, m1_gnt};
    obs_ram   = {ram_wren, ram_addr, ram_data};
    obs_rv    = {m0_rvalid, m1_rvalid};
    obs_q0    = m0_q;
    obs_q1    = m1_q;
    obs_owner = dut.owner_q;
    obs_cnt   = int'(dut.cnt_q);
    w = pick();
    last_win = w;
    wr = (w == 0) ? m0_wren : m1_wren;
    a  = (w == 0) ? m0_addr : m1_addr;
    d  = (w == 0) ? m0_data : m1_data;
    exp_gnt = {w == 0, w == 1};
    exp_ram = (w < 0) ? 29'd0 : {wr, a, d};
    now_rv  = {exp_rv0, exp_rv1};
    now_q0  = exp_q0;
    now_q1  = exp_q1;
    @(posedge clk);
    if (w >= 0 && wr) ref_mem[a] = d;
    if (rst) begin
      mdl_owner = -1; mdl_run = 0;
      exp_rv0 = 0; exp_rv1 = 0; exp_q0 = '0; exp_q1 = '0;
    end else begin
      exp_rv0 = (w == 0) && !wr;
      exp_rv1 = (w == 1) && !wr;
      if (exp_rv0) exp_q0 = ref_mem[a];
      if (exp_rv1) exp_q1 = ref_mem[a];
      if (w < 0) begin
        mdl_owner = -1; mdl_run = 0;
      end else if (w == mdl_owner) begin
        mdl_run = (mdl_run + 1 > MB) ? MB : mdl_run + 1;
      end else begin
        mdl_owner = w; mdl_run = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; m0_req = 1; m1_req = 1; m0_wren = 0; m1_wren = 0;
    m0_addr = '0; m1_addr = '0; m0_data = '0; m1_data = '0;
    cycle();
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b10) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 10", obs_gnt);
    end
    rst = 0; idle_inputs();
    cycle();
    n_tests++;
    if ({obs_rv, obs_q0, obs_q1, obs_gnt} !== {2'b00, 16'h0, 16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_outputs: rv=%b q0=%h q1=%h gnt=%b expected rv=00 q=0000/0000 gnt=00",
               obs_rv, obs_q0, obs_q1, obs_gnt);
    end
    n_tests++;
    if (obs_owner !== 2'd0 || obs_cnt != 0) begin
      n_fail++; $display("FAIL reset_state: owner=%0d cnt=%0d expected 0/0", obs_owner, obs_cnt);
    end
  endtask

  task automatic test_single_rw();
    m0_req = 1; m0_wren = 1; m0_addr = 12'h123; m0_data = 16'hBEEF;
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b10 || obs_ram !== {1'b1, 12'h123, 16'hBEEF}) begin
      n_fail++; $display("FAIL single_write: gnt=%b ram=%h expected 10 / %h", obs_gnt, obs_ram,
                         {1'b1, 12'h123, 16'hBEEF});
    end
    m0_wren = 0;
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b10 || obs_ram[28:16] !== {1'b0, 12'h123}) begin
      n_fail++; $display("FAIL single_read: gnt=%b wren/addr=%h expected 10 / 0123", obs_gnt,
                         obs_ram[28:16]);
    end
    idle_inputs();
    cycle();
    n_tests++;
    if ({obs_rv, obs_q0, obs_q1} !== {2'b10, 16'hBEEF, 16'h0000}) begin
      n_fail++; $display("FAIL single_rdata: rv=%b q0=%h q1=%h expected 10 beef 0000", obs_rv,
                         obs_q0, obs_q1);
    end
    cycle();
    n_tests++;
    if ({obs_rv, obs_q0, obs_ram} !== {2'b00, 16'hBEEF, 29'd0}) begin
      n_fail++; $display("FAIL single_hold: rv=%b q0=%h ram=%h expected 00 beef 0", obs_rv,
                         obs_q0, obs_ram);
    end
  endtask

  task automatic test_contention();
    logic [15:0] seq;
    seq = 16'b0000111100001111;  // bit 15 first: 1 means M1 granted
    m0_req = 1; m0_wren = 0; m0_addr = 12'h123;
    m1_req = 1; m1_wren = 0; m1_addr = 12'h200;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_tests++;
      if (obs_gnt !== {!seq[15-i], seq[15-i]}) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, obs_gnt,
                           {!seq[15-i], seq[15-i]});
      end
      if (i > 0) begin
        n_tests++;
        if (obs_rv !== now_rv) begin
          n_fail++; $display("FAIL contention_rv[%0d]: got %b expected %b", i, obs_rv, now_rv);
        end
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_early_release();
    m1_req = 1; m1_wren = 0; m1_addr = 12'h010;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++;
      if (obs_gnt !== 2'b01) begin
        n_fail++; $display("FAIL early_m1_gnt[%0d]: got %b expected 01", i, obs_gnt);
      end
    end
    m1_req = 0; m0_req = 1; m0_wren = 0; m0_addr = 12'h011;
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b10 || obs_cnt != 2) begin
      n_fail++; $display("FAIL early_switch: gnt=%b cnt=%0d expected 10 cnt=2", obs_gnt, obs_cnt);
    end
    m0_req = 0;
    cycle();
    n_tests++;
    if (obs_owner !== 2'd1 || obs_cnt != 1) begin
      n_fail++; $display("FAIL early_state: owner=%0d cnt=%0d expected 1/1", obs_owner, obs_cnt);
    end
  endtask

  task automatic test_saturation();
    m0_req = 1; m0_wren = 0; m0_addr = 12'h123;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++;
      if (obs_gnt !== 2'b10) begin
        n_fail++; $display("FAIL sat_m0_gnt[%0d]: got %b expected 10", i, obs_gnt);
      end
    end
    m1_req = 1; m1_wren = 1; m1_addr = 12'h0AA; m1_data = 16'h5A5A;
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b01 || obs_cnt != MB || obs_ram !== {1'b1, 12'h0AA, 16'h5A5A}) begin
      n_fail++; $display("FAIL sat_switch: gnt=%b cnt=%0d ram=%h expected 01 cnt=%0d ram=%h",
                         obs_gnt, obs_cnt, obs_ram, MB, {1'b1, 12'h0AA, 16'h5A5A});
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_read();
    m1_req = 1; m1_wren = 0; m1_addr = 12'h123;
    cycle();
    idle_inputs();
    cycle();
    n_tests++;
    if ({obs_rv, obs_q1} !== {2'b01, 16'hBEEF}) begin
      n_fail++; $display("FAIL rst_pre_read: rv=%b q1=%h expected 01 beef", obs_rv, obs_q1);
    end
    m1_req = 1; rst = 1;
    cycle();
    n_tests++;
    if (obs_gnt !== 2'b01) begin
      n_fail++; $display("FAIL rst_read_gnt: got %b expected 01", obs_gnt);
    end
    rst = 0; idle_inputs();
    cycle();
    n_tests++;
    if ({obs_rv, obs_q0, obs_q1, obs_owner} !== {2'b00, 16'h0, 16'h0, 2'd0} || obs_cnt != 0) begin
      n_fail++; $display("FAIL rst_mid_read: rv=%b q0=%h q1=%h owner=%0d cnt=%0d expected 00 0 0 0 0",
                         obs_rv, obs_q0, obs_q1, obs_owner, obs_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (!m0_req || last_win == 0) begin
        m0_req  = ($urandom_range(0, 9) < 7);
        m0_wren = $urandom_range(0, 1);
        m0_addr = AW'($urandom_range(0, 15));
        m0_data = DW'($urandom);
      end
      if (!m1_req || last_win == 1) begin
        m1_req  = ($urandom_range(0, 9) < 6);
        m1_wren = $urandom_range(0, 1);
        m1_addr = AW'($urandom_range(0, 15));
        m1_data = DW'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      n_tests++;
      if (obs_gnt !== exp_gnt || obs_ram !== exp_ram) begin
        n_fail++; $display("FAIL rand_grant[%0d]: gnt=%b ram=%h expected %b %h", i, obs_gnt,
                           obs_ram, exp_gnt, exp_ram);
      end
      n_tests++;
      if ({obs_rv, obs_q0, obs_q1} !== {now_rv, now_q0, now_q1}) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: rv=%b q0=%h q1=%h expected %b %h %h", i, obs_rv,
                           obs_q0, obs_q1, now_rv, now_q0, now_q1);
      end
    end
    rst = 0; idle_inputs();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_q = '0;
    mdl_owner = -1; mdl_run = 0; last_win = -1;
    exp_rv0 = 0; exp_rv1 = 0; exp_q0 = '0; exp_q1 = '0;
    test_reset();
    test_single_rw();
    test_contention();
    test_early_release();
    test_saturation();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 4K x 16 RAM. Master 0 is the CPU core. Master 1 is a secondary bus master such as a video-fetch or DMA engine. The block sits between the requesters and the RAM, replacing static select-line muxing. It grants at most one access per cycle, enforces a bounded-burst round-robin policy so neither master starves, and returns read data to the granted master with a fixed one-cycle latency.

## Interface
Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 16, RAM data width
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting (≥1)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- M0_REQ  in  1  master 0 access request
- M0_WREN  in  1  1 = write, 0 = read
- M0_ADDR  in  ADDR_W  access address
- M0_DATA  in  DATA_W  write data
- M0_GNT  out  1  access performed this cycle (combinational)
- M0_RVALID  out  1  M0_Q holds read data (registered)
- M0_Q  out  DATA_W  read data (registered)
- M1_REQ, M1_WREN, M1_ADDR, M1_DATA, M1_GNT, M1_RVALID, M1_Q: same as the M0 group, for master 1
- RAM_ADDR  out  ADDR_W  to RAM address
- RAM_WREN  out  1  to RAM write enable
- RAM_DATA  out  DATA_W  to RAM write data
- RAM_Q  in  DATA_W  RAM read data (RAM clocked on inverted CLK; valid before the next rising edge)

## Operation
- State: OWNER ∈ {IDLE, OWN0, OWN1}, CNT (0..MAX_BURST, saturating).
- Requester rule: a master holds REQ, WREN, ADDR and DATA stable until it sees GNT high. The access completes in the GNT cycle. The master may change its request fields in the following cycle.
- Winner selection for the current cycle is combinational from OWNER, CNT and the REQ inputs:
  - IDLE: M0 if M0_REQ, else M1 if M1_REQ, else none.
  - OWNx with x requesting, and (other not requesting or CNT < MAX_BURST): x.
  - Otherwise, if the other master is requesting: the other master.
  - Otherwise: none.
- Next state:
  - Winner w equal to the current owner: OWNER stays, CNT = min(CNT+1, MAX_BURST).
  - Winner w new: OWNER = OWNw, CNT = 1.
  - No winner: OWNER = IDLE, CNT = 0.
- GNT for the winner is 1; GNT for the other master is 0.
- RAM_ADDR, RAM_DATA and RAM_WREN are the winner's fields.
- With no winner: RAM_WREN = 0, and RAM_ADDR/RAM_DATA are 0.
- RAM_WREN is never 1 unless a write is granted.
- Read return: on a granted read at cycle N, at the rising edge ending cycle N:
  - Mw_Q ← RAM_Q.
  - Mw_RVALID = 1 for cycle N+1 only.
  - The other master's Q and RVALID are unaffected.
- Mx_Q holds its last value when RVALID is 0.
- Writes produce no RVALID.
- Back-to-back reads from one master give RVALID high on consecutive cycles.
- Reset: OWNER = IDLE, CNT = 0, M0_Q = M1_Q = 0, M0_RVALID = M1_RVALID = 0.
  - If RST is high during a grant cycle, that access's RVALID is suppressed.
  - Combinational GNT and RAM outputs are still driven during the RST cycle. A write granted in that cycle reaches the RAM.

## Timing
- Grant latency: 0 cycles. GNT is in the same cycle as REQ when that master wins.
- Read latency: 1 cycle (RVALID/Q in cycle N+1 for a grant in cycle N).
- Throughput: 1 access per cycle total.
- Fairness under continuous contention:
  - MAX_BURST grants to M0, then MAX_BURST grants to M1, alternating.
  - The worst-case wait for a requesting master is MAX_BURST cycles.
- Simultaneous first requests from IDLE: M0 wins.
- Owner dropping REQ while the other requests: switch with no idle cycle.
- Owner continues past MAX_BURST while the other master is idle: CNT saturates and the owner keeps the grant.
- MAX_BURST = 1: strict alternation under contention.

## Test plan
- Reset: RST=1 for 2 cycles with both REQ=1 → after RST drops, OWNER=IDLE, CNT=0, RVALIDs 0, both Q = 0x0000.
- Single master write/read: M0 writes 0xBEEF to 0x123, then reads 0x123 → GNT in each request cycle, M0_RVALID=1 in the cycle after the read grant with M0_Q=0xBEEF, M1 outputs unchanged.
- Contention, MAX_BURST=4: both REQ held high from IDLE for 16 cycles → grant sequence 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1. Exactly one GNT per cycle.
- Early release: M1 owns with CNT=2 and M1_REQ drops while M0_REQ=1 → M0_GNT that same cycle, CNT=1 next. No idle cycle.
- Saturation: M0 requests alone for 10 cycles, then M1 requests → M1 granted the next cycle (CNT already at MAX_BURST).
- Reset mid-read: M1 read granted in the cycle RST=1 → no M1_RVALID in the next cycle, state IDLE.
